// File: rtl/npu_loader_pkg.sv
// Shared types for the NPU weight loader: command opcodes, FSM states and region selects.
package npu_loader_pkg;

    typedef enum logic [1:0] {
        OP_ABORT = 2'b00,
        OP_LOAD  = 2'b01,
        OP_READ  = 2'b10,
        OP_CLEAR = 2'b11
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_CONV,
        ST_LOAD_DENSE,
        ST_READ_RUN,
        ST_DRAIN
    } state_e;

    localparam logic REGION_CONV  = 1'b0;
    localparam logic REGION_DENSE = 1'b1;

endpackage

// File: rtl/npu_weight_loader_ram.sv
// Simple dual-port weight RAM: one write port, one synchronous read port (1-cycle latency).
module npu_sdp_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/npu_weight_loader.sv
// Avalon-commanded weight loader: streams words into a conv/dense banked RAM and reads regions back.
// Optional NPU_LOADER_CHECKSUM_EN adds a running XOR checksum output of loaded words.
//
// state         | meaning
// ST_IDLE       | waiting for LOAD or READ
// ST_LOAD_CONV  | accepting words into the conv region
// ST_LOAD_DENSE | accepting words into the dense region
// ST_READ_RUN   | issuing RAM reads for the selected region
// ST_DRAIN      | last read issued, emptying in-flight data and FIFO
module npu_weight_loader
    import npu_loader_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int LANES       = DATA_W / 8,
    parameter int CONV_WORDS  = 1024,
    parameter int DENSE_WORDS = 4096,
    parameter int ADDR_W      = $clog2(CONV_WORDS + DENSE_WORDS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               chipselect,
    input  logic               write,
    input  logic [31:0]        writedata,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*8-1:0] out_data,
    output logic               out_last,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic [ADDR_W-1:0]  conv_addr,
    output logic [ADDR_W-1:0]  dense_addr,
    output logic               busy,
    output logic               done,
    output logic               cmd_err
`ifdef NPU_LOADER_CHECKSUM_EN
    ,
    output logic [31:0]        checksum
`endif
);

    localparam int TOTAL = CONV_WORDS + DENSE_WORDS;
    localparam logic [ADDR_W-1:0] CONV_LAST  = ADDR_W'(CONV_WORDS - 1);
    localparam logic [ADDR_W-1:0] DENSE_LAST = ADDR_W'(DENSE_WORDS - 1);
    localparam logic [ADDR_W-1:0] DENSE_BASE = ADDR_W'(CONV_WORDS);
    localparam logic [ADDR_W-1:0] TOTAL_LAST = ADDR_W'(TOTAL - 1);
    localparam logic [ADDR_W-1:0] ONE        = ADDR_W'(1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [ADDR_W-1:0] conv_addr_q, conv_addr_d;
    logic [ADDR_W-1:0] dense_addr_q, dense_addr_d;
    logic              done_q, done_d, err_q, err_d;
    logic              region_q, region_d;
    logic              inflight_q, inflight_d, infl_last_q, infl_last_d;

    logic [DATA_W-1:0] fifo_data_q [2];
    logic              fifo_last_q [2];
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        fifo_cnt_q, fifo_occ;

    logic              cmd_vld, beat, rd_issue, flush, push, pop;
    opcode_e           cmd_op;
    logic [ADDR_W-1:0] region_end;
    logic [DATA_W-1:0] ram_rdata;
    logic              unused_cmd_bits;

    assign cmd_vld         = chipselect & write;
    assign cmd_op          = opcode_e'(writedata[1:0]);
    assign unused_cmd_bits = ^writedata[31:3];
    assign in_ready        = (state_q == ST_LOAD_CONV) || (state_q == ST_LOAD_DENSE);
    assign beat            = in_valid & in_ready;
    assign region_end      = (region_q == REGION_DENSE) ? TOTAL_LAST : CONV_LAST;
    assign fifo_occ        = fifo_cnt_q + {1'b0, inflight_q};

    always_comb begin
        state_d      = state_q;
        ram_addr_d   = ram_addr_q;
        conv_addr_d  = conv_addr_q;
        dense_addr_d = dense_addr_q;
        done_d       = done_q;
        err_d        = err_q;
        region_d     = region_q;
        inflight_d   = 1'b0;
        infl_last_d  = infl_last_q;
        rd_issue     = 1'b0;
        flush        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_vld) begin
                    case (cmd_op)
                        OP_LOAD: begin
                            state_d      = ST_LOAD_CONV;
                            done_d       = 1'b0;
                            ram_addr_d   = '0;
                            conv_addr_d  = '0;
                            dense_addr_d = '0;
                        end
                        OP_READ: begin
                            state_d    = ST_READ_RUN;
                            region_d   = writedata[2];
                            ram_addr_d = (writedata[2] == REGION_DENSE) ? DENSE_BASE : '0;
                        end
                        OP_CLEAR: begin
                            done_d = 1'b0;
                            err_d  = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_LOAD_CONV: begin
                if (beat) begin
                    ram_addr_d  = ram_addr_q + ONE;
                    conv_addr_d = conv_addr_q + ONE;
                    if (conv_addr_q == CONV_LAST) state_d = ST_LOAD_DENSE;
                end
            end
            ST_LOAD_DENSE: begin
                if (beat) begin
                    dense_addr_d = dense_addr_q + ONE;
                    if (dense_addr_q == DENSE_LAST) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        ram_addr_d = ram_addr_q + ONE;
                    end
                end
            end
            ST_READ_RUN: begin
                // Reads only while the FIFO can absorb everything already requested.
                rd_issue = (fifo_occ < 2'd2);
                if (rd_issue) begin
                    inflight_d  = 1'b1;
                    infl_last_d = (ram_addr_q == region_end);
                    if (ram_addr_q == region_end) state_d = ST_DRAIN;
                    else ram_addr_d = ram_addr_q + ONE;
                end
            end
            ST_DRAIN: begin
                if (fifo_cnt_q == 2'd0 && !inflight_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // A beat in this cycle has already been handled above; the command is applied on top.
        if (cmd_vld && state_q != ST_IDLE) begin
            if (cmd_op == OP_ABORT) begin
                state_d    = ST_IDLE;
                flush      = 1'b1;
                inflight_d = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            ram_addr_q   <= '0;
            conv_addr_q  <= '0;
            dense_addr_q <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            region_q     <= REGION_CONV;
            inflight_q   <= 1'b0;
            infl_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ram_addr_q   <= ram_addr_d;
            conv_addr_q  <= conv_addr_d;
            dense_addr_q <= dense_addr_d;
            done_q       <= done_d;
            err_q        <= err_d;
            region_q     <= region_d;
            inflight_q   <= inflight_d;
            infl_last_q  <= infl_last_d;
        end
    end

    assign push = inflight_q & ~flush;
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_last_q[i] <= 1'b0;
            end
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_cnt_q <= 2'd0;
        end else if (flush) begin
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_cnt_q <= 2'd0;
        end else begin
            if (push) begin
                fifo_data_q[wr_ptr_q] <= ram_rdata;
                fifo_last_q[wr_ptr_q] <= infl_last_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            fifo_cnt_q <= fifo_cnt_q + 2'(push) - 2'(pop);
        end
    end

    npu_sdp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (TOTAL)
    ) u_ram (
        .clk     (clk),
        .we_i    (beat),
        .waddr_i (ram_addr_q),
        .wdata_i (in_data),
        .re_i    (rd_issue),
        .raddr_i (ram_addr_q),
        .rdata_o (ram_rdata)
    );

    assign out_valid  = (fifo_cnt_q != 2'd0);
    assign out_data   = out_valid ? (LANES*8)'(fifo_data_q[rd_ptr_q]) : '0;
    assign out_last   = out_valid & fifo_last_q[rd_ptr_q];
    assign ram_addr   = ram_addr_q;
    assign conv_addr  = conv_addr_q;
    assign dense_addr = dense_addr_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign cmd_err    = err_q;

`ifdef NPU_LOADER_CHECKSUM_EN
    logic [31:0] csum_q, csum_fold;

    // Wide words fold onto 32 bits by XOR; narrow words are zero-extended.
    always_comb begin
        csum_fold = '0;
        for (int i = 0; i < DATA_W; i++) csum_fold[5'(i % 32)] ^= in_data[i];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) csum_q <= '0;
        else if (state_q == ST_IDLE && cmd_vld && cmd_op == OP_LOAD) csum_q <= '0;
        else if (beat) csum_q <= csum_q ^ csum_fold;
    end

    assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_npu_weight_loader.sv
// Self-checking bench for npu_weight_loader (8 conv + 8 dense words); checks checksum when NPU_LOADER_CHECKSUM_EN is set.
module tb_npu_weight_loader;

    localparam int CONV_WORDS  = 8;
    localparam int DENSE_WORDS = 8;
    localparam int NW          = CONV_WORDS + DENSE_WORDS;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        chipselect = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_last;
    logic [3:0]  ram_addr, conv_addr, dense_addr;
    logic        busy, done, cmd_err;
`ifdef NPU_LOADER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] ref_mem [NW];
    logic [31:0] ref_csum = '0;
    logic [31:0] last_word = '0;
    logic [31:0] words [NW];

    npu_weight_loader #(
        .DATA_W      (32),
        .CONV_WORDS  (CONV_WORDS),
        .DENSE_WORDS (DENSE_WORDS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .write      (write),
        .writedata  (writedata),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .ram_addr   (ram_addr),
        .conv_addr  (conv_addr),
        .dense_addr (dense_addr),
        .busy       (busy),
        .done       (done),
        .cmd_err    (cmd_err)
`ifdef NPU_LOADER_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    typedef struct {
        logic [31:0] wd;
        logic        busy;
        logic        err;
        logic        done;
        logic        rdy;
    } cmd_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_cmd(input logic [31:0] wd);
        chipselect = 1'b1;
        write      = 1'b1;
        writedata  = wd;
        step();
        chipselect = 1'b0;
        write      = 1'b0;
        writedata  = '0;
    endtask

    // Loads NW words; cmd_at >= 0 fires a READ in the same cycle as that word's beat.
    task automatic load_words(input logic [31:0] w [NW], input bit rand_v, input int cmd_at);
        int idx = 0;
        int cyc = 0;
        bit issued = 0;
        bit accepted;
        send_cmd(32'h1);
        ref_csum = '0;
        chk("load_ready", in_ready, 1);
        chk("load_done_clr", done, 0);
        while (idx < NW && cyc < 200) begin
            in_valid = rand_v ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = w[idx];
            if (idx == cmd_at && !issued) begin
                chipselect = 1'b1;
                write      = 1'b1;
                writedata  = 32'h2;
                issued     = 1;
            end
            accepted = in_valid && in_ready;
            step();
            chipselect = 1'b0;
            write      = 1'b0;
            writedata  = '0;
            cyc++;
            if (accepted) begin
                ref_mem[idx] = w[idx];
                ref_csum ^= w[idx];
                idx++;
                if (idx == CONV_WORDS) begin
                    chk("conv_full_addr", conv_addr, CONV_WORDS);
                    chk("conv_full_dense", dense_addr, 0);
                    chk("no_bubble_ready", in_ready, 1);
                end
            end
        end
        in_valid = 1'b0;
        chk("load_count", idx, NW);
        if (!rand_v) chk("load_cycles", cyc, NW);
        chk("load_conv_addr", conv_addr, CONV_WORDS);
        chk("load_dense_addr", dense_addr, DENSE_WORDS);
        chk("load_done", done, 1);
        chk("load_idle", busy, 0);
`ifdef NPU_LOADER_CHECKSUM_EN
        chk("checksum", checksum, ref_csum);
`endif
    endtask

    // mode 0: out_ready toggles 1/0, 1: random, 2: always ready
    task automatic read_region(input bit rgn, input int mode);
        int n = 0;
        int cyc = 0;
        int base = rgn ? CONV_WORDS : 0;
        bit r;
        send_cmd(rgn ? 32'h6 : 32'h2);
        chk("read_busy", busy, 1);
        while (n < 8 && cyc < 200) begin
            if (mode == 0) r = (cyc % 2 == 0);
            else if (mode == 1) r = 1'($urandom_range(0, 1));
            else r = 1'b1;
            out_ready = r;
            if (out_valid && r) begin
                chk("read_word", out_data, ref_mem[base + n]);
                chk("read_last", out_last, (n == 7));
                last_word = out_data;
                n++;
            end
            step();
            cyc++;
        end
        out_ready = 1'b0;
        chk("read_count", n, 8);
        cyc = 0;
        while (busy && cyc < 10) begin
            step();
            cyc++;
        end
        chk("read_idle", busy, 0);
        chk("read_out_valid", out_valid, 0);
    endtask

    initial begin
        cmd_vec_t tbl [12];
        int n;
        int cyc;

        tbl[0]  = '{32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{32'h0000_0003, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{32'h0000_0006, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{32'h0000_0001, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{32'h0000_0003, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{32'h0000_0003, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{32'h0000_0004, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{32'hABCD_0001, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{32'h0000_0002, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0};

        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_conv_addr", conv_addr, 0);
        chk("rst_dense_addr", dense_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cmd_err", cmd_err, 0);

        // Continuous load of 1..16, then dense readout with toggling ready.
        for (int i = 0; i < NW; i++) words[i] = 32'(i + 1);
        load_words(words, 1'b0, -1);
        read_region(1'b1, 0);
        chk("last_lane0", {24'h0, last_word[7:0]}, 32'h10);
        chk("last_lanes_hi", {8'h0, last_word[31:8]}, 32'h0);

        // Abort after three conv words with out_ready low.
        send_cmd(32'h2);
        n = 0;
        cyc = 0;
        while (n < 3 && cyc < 50) begin
            out_ready = 1'b1;
            if (out_valid) begin
                chk("pre_abort_word", out_data, ref_mem[n]);
                n++;
            end
            step();
            cyc++;
        end
        out_ready = 1'b0;
        chk("pre_abort_count", n, 3);
        send_cmd(32'h0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done_kept", done, 1);
        read_region(1'b0, 2);

        // READ issued together with the sixth beat: rejected, load carries on.
        for (int i = 0; i < NW; i++) words[i] = 32'h100 + 32'(i);
        load_words(words, 1'b0, 5);
        chk("midload_cmd_err", cmd_err, 1);

        for (int i = 0; i < 12; i++) begin
            send_cmd(tbl[i].wd);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
            chk($sformatf("tbl%0d_err", i), cmd_err, tbl[i].err);
            chk($sformatf("tbl%0d_done", i), done, tbl[i].done);
            chk($sformatf("tbl%0d_rdy", i), in_ready, tbl[i].rdy);
        end

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NW; i++) words[i] = $urandom;
            load_words(words, 1'b1, -1);
            read_region(1'($urandom_range(0, 1)), 1);
            read_region(1'(r % 2), 2);
        end

        // Asynchronous reset in the middle of a load.
        send_cmd(32'h1);
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        step();
        step();
        step();
        in_valid = 1'b0;
        chk("pre_rst_conv_addr", conv_addr, 3);
        #1 reset = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_conv_addr", conv_addr, 0);
        chk("midrst_ram_addr", ram_addr, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_done", done, 0);
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("post_rst_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
